// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding controller.
// Tags follow each in-flight instruction through EX, MEM and WB.
package fwd_pkg;

  localparam int TAG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] dst;
    logic              we;
    logic              load;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  function automatic logic tag_writing(input stage_tag_t t);
    return t.valid && t.we && (t.dst != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Priority compare of one EX source register against the MEM and WB tags.
// MEM wins because it carries the younger result.
import fwd_pkg::*;

module fwd_sel_cmp #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  stage_tag_t        mem,
  input  stage_tag_t        wb,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = ex_valid && use_src && tag_writing(mem)
                && (REG_AW'(mem.dst) == src);
  assign wb_hit  = ex_valid && use_src && tag_writing(wb)
                && (REG_AW'(wb.dst) == src) && !mem_hit;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      mem_hit: sel = FWD_MEM;
      wb_hit:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding-select and load-use stall controller for the EX stage.
// Tag pipeline EX -> MEM -> WB; selects come purely from registers.
import fwd_pkg::*;

module fwd_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_valid
);

  stage_tag_t        ex_q;
  stage_tag_t        mem_q;
  stage_tag_t        wb_q;
  stage_tag_t        ex_d;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  logic              ex_use_rs_q;
  logic              ex_use_rt_q;
  logic              ex_take;
  logic              rs_dep;
  logic              rt_dep;
  logic              unused_load;

  // Load results are never forwarded from MEM; the stall makes that safe.
  assign unused_load = mem_q.load ^ wb_q.load;

  assign rs_dep = id_use_rs && (id_rs == REG_AW'(ex_q.dst));
  assign rt_dep = id_use_rt && (id_rt == REG_AW'(ex_q.dst));

  assign stall = id_valid && !flush && tag_writing(ex_q)
              && ex_q.load && (rs_dep || rt_dep);

  assign ex_take = id_valid && !flush && !stall;

  always_comb begin
    ex_d = TAG_BUBBLE;
    if (ex_take) begin
      ex_d.valid = 1'b1;
      ex_d.dst   = TAG_AW'(id_dst);
      ex_d.we    = id_we;
      ex_d.load  = id_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= TAG_BUBBLE;
      mem_q       <= TAG_BUBBLE;
      wb_q        <= TAG_BUBBLE;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      ex_rs_q     <= ex_take ? id_rs : '0;
      ex_rt_q     <= ex_take ? id_rt : '0;
      ex_use_rs_q <= ex_take && id_use_rs;
      ex_use_rt_q <= ex_take && id_use_rt;
    end
  end

  assign ex_valid = ex_q.valid;

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .ex_valid (ex_q.valid),
    .use_src  (ex_use_rs_q),
    .src      (ex_rs_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .ex_valid (ex_q.valid),
    .use_src  (ex_use_rt_q),
    .src      (ex_rt_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_b_sel)
  );

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: forwarding distances, load-use stall,
// register zero, flush priority and asynchronous reset.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_we;
  logic       id_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       ex_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_ctrl #(.REG_AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_dst    (id_dst),
    .id_we     (id_we),
    .id_load   (id_load),
    .flush     (flush),
    .stall     (stall),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel),
    .ex_valid  (ex_valid)
  );

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] dst,
                       input logic we, input logic ld);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_dst    = dst;
    id_we     = we;
    id_load   = ld;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    repeat (3) cyc();
  endtask

  // Structural checks that must hold on every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_not_11", {1'b0, fwd_a_sel == 2'b11}, 2'b00);
      chk("b_not_11", {1'b0, fwd_b_sel == 2'b11}, 2'b00);
      if (fwd_a_sel == 2'b10 || fwd_b_sel == 2'b10)
        chk("mem_fwd_not_load", {1'b0, dut.mem_q.load}, 2'b00);
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    repeat (2) cyc();
    chk("rst_stall", {1'b0, stall}, 2'b00);
    chk("rst_a", fwd_a_sel, 2'b00);
    chk("rst_b", fwd_b_sel, 2'b00);
    chk("rst_exv", {1'b0, ex_valid}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("rel_exv0", {1'b0, ex_valid}, 2'b00);
    cyc();
    chk("rel_exv1", {1'b0, ex_valid}, 2'b01);
    drain();

    // distance 1 -> MEM forward
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    cyc();
    drive(1, 3, 7, 1, 1, 6, 1, 0);
    cyc();
    chk("d1_a", fwd_a_sel, 2'b10);
    chk("d1_b", fwd_b_sel, 2'b00);
    drain();

    // distance 2 -> WB forward
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    cyc();
    drive(1, 8, 9, 1, 1, 10, 1, 0);
    cyc();
    drive(1, 3, 7, 1, 1, 6, 1, 0);
    cyc();
    chk("d2_a", fwd_a_sel, 2'b01);
    drain();

    // distance 3 -> register file
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    cyc();
    drive(1, 8, 9, 1, 1, 10, 1, 0);
    cyc();
    drive(1, 8, 9, 1, 1, 11, 1, 0);
    cyc();
    drive(1, 3, 7, 1, 1, 6, 1, 0);
    cyc();
    chk("d3_a", fwd_a_sel, 2'b00);
    chk("d3_exv", {1'b0, ex_valid}, 2'b01);
    drain();

    // $5 in both MEM and WB; MEM must win on rt
    drive(1, 1, 2, 1, 1, 5, 1, 0);
    cyc();
    drive(1, 1, 0, 1, 0, 5, 1, 0);
    cyc();
    drive(1, 2, 5, 1, 1, 12, 1, 0);
    cyc();
    chk("dbl_b", fwd_b_sel, 2'b10);
    chk("dbl_a", fwd_a_sel, 2'b00);
    drain();

    // load-use: one stall cycle then WB forward
    drive(1, 1, 0, 1, 0, 4, 1, 1);
    cyc();
    drive(1, 6, 4, 1, 1, 7, 1, 0);
    chk("lu_stall", {1'b0, stall}, 2'b01);
    cyc();
    chk("lu_stall_once", {1'b0, stall}, 2'b00);
    chk("lu_bubble", {1'b0, ex_valid}, 2'b00);
    cyc();
    chk("lu_exv", {1'b0, ex_valid}, 2'b01);
    chk("lu_b", fwd_b_sel, 2'b01);
    chk("lu_a", fwd_a_sel, 2'b00);
    drain();

    // register zero never forwards or stalls
    drive(1, 1, 0, 1, 0, 0, 1, 1);
    cyc();
    drive(1, 0, 0, 1, 1, 7, 1, 0);
    chk("z_stall", {1'b0, stall}, 2'b00);
    cyc();
    chk("z_a", fwd_a_sel, 2'b00);
    chk("z_b", fwd_b_sel, 2'b00);
    chk("z_exv", {1'b0, ex_valid}, 2'b01);
    drain();

    // rs == rt: both selects match
    drive(1, 1, 2, 1, 1, 9, 1, 0);
    cyc();
    drive(1, 9, 9, 1, 1, 13, 1, 0);
    cyc();
    chk("same_a", fwd_a_sel, 2'b10);
    chk("same_b", fwd_b_sel, 2'b10);
    drain();

    // flush beats stall; lw still advances to WB
    drive(1, 1, 0, 1, 0, 4, 1, 1);
    cyc();
    flush = 1'b1;
    drive(1, 6, 4, 1, 1, 7, 1, 0);
    chk("fl_stall", {1'b0, stall}, 2'b00);
    cyc();
    flush = 1'b0;
    chk("fl_bubble", {1'b0, ex_valid}, 2'b00);
    drive(1, 4, 1, 1, 0, 8, 1, 0);
    chk("fl_nostall", {1'b0, stall}, 2'b00);
    cyc();
    chk("fl_a", fwd_a_sel, 2'b01);
    drain();

    // asynchronous reset mid-stream
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    cyc();
    drive(1, 3, 3, 1, 1, 6, 1, 0);
    cyc();
    chk("mr_pre_a", fwd_a_sel, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mr_a", fwd_a_sel, 2'b00);
    chk("mr_b", fwd_b_sel, 2'b00);
    chk("mr_exv", {1'b0, ex_valid}, 2'b00);
    chk("mr_stall", {1'b0, stall}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
